ponto_fixo_multi8: RTL and testbench

- Unsigned fixed-point multiplier for Qm.n operands, N bits wide, with NFRAC fractional bits.
- Produces the full-precision product in Q(2m).(2n).
- Produces a product rescaled back to Qm.n, with round-half-up and optional saturation, plus an overflow flag.
- Single registered stage: inputs are sampled on a valid strobe, and results appear one cycle later.
- Used as the arithmetic leaf in datapath exercises. Default format is Q5.3; Q3.5 is supported via NFRAC=5.

---
 rtl/ponto_fixo_multi8_pkg.sv | 17 +
 rtl/ponto_fixo_multi8_if.sv | 37 +++
 rtl/ponto_fixo_mult_core.sv | 40 ++++
 rtl/ponto_fixo_multi8.sv | 69 ++++++
 tb/tb_ponto_fixo_multi8.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ponto_fixo_multi8_pkg.sv
// Shared constants and helpers for the unsigned Qm.n fixed-point multiplier.
package ponto_fixo_multi8_pkg;

    // Default operand format: Q5.3 on 8 bits.
    localparam int unsigned DEF_N     = 8;
    localparam int unsigned DEF_NFRAC = 3;

    // Value added before the right shift to get round-half-up.
    // With no fractional bits there is nothing to round, so the constant is zero.
    function automatic int unsigned round_const(input int unsigned nfrac);
        if (nfrac == 0) begin
            return 0;
        end
        return 32'd1 << (nfrac - 1);
    endfunction

endpackage

// File: rtl/ponto_fixo_multi8_if.sv
// Operand/result bundle of the fixed-point multiplier.
// master drives operands and observes results; slave is the multiplier side.
interface ponto_fixo_multi8_if
    import ponto_fixo_multi8_pkg::*;
#(
    parameter int unsigned N = DEF_N
);

    logic             in_valid;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic [2*N-1:0]   p_raw;
    logic [N-1:0]     p_qm_n;
    logic             overflow;

    modport master (
        output in_valid,
        output a,
        output b,
        input  out_valid,
        input  p_raw,
        input  p_qm_n,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output out_valid,
        output p_raw,
        output p_qm_n,
        output overflow
    );

endinterface

// File: rtl/ponto_fixo_mult_core.sv
// Combinational core: exact product, round-half-up rescale to Qm.n, saturation and overflow.
module ponto_fixo_mult_core
    import ponto_fixo_multi8_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned NFRAC    = DEF_NFRAC,
    parameter bit          SATURATE = 1'b1
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] raw,
    output logic [N-1:0]   p_qm_n,
    output logic           overflow
);

    // One extra bit above the product so the rounding carry is never dropped.
    localparam int unsigned W = 2 * N + 1;
    localparam logic [W-1:0] RND = W'(round_const(NFRAC));

    logic [W-1:0] rounded;
    logic [W-1:0] rescaled;

    // Exact product, then add half an LSB of the target format and drop the extra fraction bits.
    always_comb begin
        raw      = (2 * N)'(a) * (2 * N)'(b);
        rounded  = {1'b0, raw} + RND;
        rescaled = rounded >> NFRAC;
    end

    // Anything above bit N-1 means the Qm.n result does not fit; clamp or wrap.
    always_comb begin
        overflow = |rescaled[W-1:N];
        if (overflow && SATURATE) begin
            p_qm_n = '1;
        end else begin
            p_qm_n = rescaled[N-1:0];
        end
    end

endmodule

// File: rtl/ponto_fixo_multi8.sv
// Unsigned Qm.n fixed-point multiplier with a single registered output stage.
// Results of a valid operand pair appear one cycle later; data outputs hold between valids.
module ponto_fixo_multi8
    import ponto_fixo_multi8_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned NFRAC    = DEF_NFRAC,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    ponto_fixo_multi8_if.slave  bus
);

    logic [2*N-1:0] core_raw;
    logic [N-1:0]   core_qm_n;
    logic           core_overflow;

    logic           out_valid_d, out_valid_q;
    logic [2*N-1:0] p_raw_d,     p_raw_q;
    logic [N-1:0]   p_qm_n_d,    p_qm_n_q;
    logic           overflow_d,  overflow_q;

    ponto_fixo_mult_core #(
        .N        (N),
        .NFRAC    (NFRAC),
        .SATURATE (SATURATE)
    ) u_core (
        .a        (bus.a),
        .b        (bus.b),
        .raw      (core_raw),
        .p_qm_n   (core_qm_n),
        .overflow (core_overflow)
    );

    // Capture new results only on a valid strobe; otherwise hold the last product.
    always_comb begin
        out_valid_d = bus.in_valid;
        p_raw_d     = p_raw_q;
        p_qm_n_d    = p_qm_n_q;
        overflow_d  = overflow_q;
        if (bus.in_valid) begin
            p_raw_d    = core_raw;
            p_qm_n_d   = core_qm_n;
            overflow_d = core_overflow;
        end
    end

    // Output register stage, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            p_raw_q     <= '0;
            p_qm_n_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            p_raw_q     <= p_raw_d;
            p_qm_n_q    <= p_qm_n_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.p_raw     = p_raw_q;
    assign bus.p_qm_n    = p_qm_n_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ponto_fixo_multi8.sv
// Bench for ponto_fixo_multi8: three instances (Q5.3 saturating, Q5.3 wrapping, Q3.5
// saturating) share one operand stream; a queue-based scoreboard holds expected results.
module tb_ponto_fixo_multi8;

    typedef struct packed {
        logic             vld;
        logic [2:0][15:0] raw;
        logic [2:0][7:0]  q;
        logic [2:0]       ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    logic       in_valid_s;
    logic [7:0] a_s;
    logic [7:0] b_s;

    int n_checks = 0;
    int n_errors = 0;

    exp_t exp_q[$];

    logic [2:0][15:0] last_raw;
    logic [2:0][7:0]  last_q;
    logic [2:0]       last_ovf;

    logic [2:0]       obs_vld;
    logic [2:0][15:0] obs_raw;
    logic [2:0][7:0]  obs_q;
    logic [2:0]       obs_ovf;

    ponto_fixo_multi8_if #(.N(8)) if0 ();
    ponto_fixo_multi8_if #(.N(8)) if1 ();
    ponto_fixo_multi8_if #(.N(8)) if2 ();

    assign if0.in_valid = in_valid_s;
    assign if0.a        = a_s;
    assign if0.b        = b_s;
    assign if1.in_valid = in_valid_s;
    assign if1.a        = a_s;
    assign if1.b        = b_s;
    assign if2.in_valid = in_valid_s;
    assign if2.a        = a_s;
    assign if2.b        = b_s;

    assign obs_vld[0] = if0.out_valid;
    assign obs_raw[0] = if0.p_raw;
    assign obs_q[0]   = if0.p_qm_n;
    assign obs_ovf[0] = if0.overflow;
    assign obs_vld[1] = if1.out_valid;
    assign obs_raw[1] = if1.p_raw;
    assign obs_q[1]   = if1.p_qm_n;
    assign obs_ovf[1] = if1.overflow;
    assign obs_vld[2] = if2.out_valid;
    assign obs_raw[2] = if2.p_raw;
    assign obs_q[2]   = if2.p_qm_n;
    assign obs_ovf[2] = if2.overflow;

    ponto_fixo_multi8 #(.N(8), .NFRAC(3), .SATURATE(1'b1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    ponto_fixo_multi8 #(.N(8), .NFRAC(3), .SATURATE(1'b0)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    ponto_fixo_multi8 #(.N(8), .NFRAC(5), .SATURATE(1'b1)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nfrac_of(input int k);
        return (k == 2) ? 5 : 3;
    endfunction

    function automatic bit sat_of(input int k);
        return (k != 1);
    endfunction

    // Reference: exact product, then round-half-up division by 2^nfrac.
    task automatic model(input int nfrac, input bit sat, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] raw, output logic [7:0] q, output logic ovf);
        longint unsigned rw;
        longint unsigned r;
        rw = longint'(a) * longint'(b);
        if (nfrac == 0) r = rw;
        else r = (rw + (longint'(1) << (nfrac - 1))) / (longint'(1) << nfrac);
        raw = 16'(rw);
        ovf = (r > 255);
        q   = (ovf && sat) ? 8'hFF : 8'(r);
    endtask

    task automatic clear_model();
        last_raw = '0;
        last_q   = '0;
        last_ovf = '0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, predict the result and compare it after the edge.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        exp_t o;
        @(negedge clk);
        in_valid_s = v;
        a_s        = a;
        b_s        = b;
        e.vld = v;
        for (int k = 0; k < 3; k++) begin
            if (v) begin
                model(nfrac_of(k), sat_of(k), a, b, last_raw[k], last_q[k], last_ovf[k]);
            end
            e.raw[k] = last_raw[k];
            e.q[k]   = last_q[k];
            e.ovf[k] = last_ovf[k];
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard empty", 64'd0, 64'd1);
        end else begin
            o = exp_q.pop_front();
            for (int k = 0; k < 3; k++) begin
                check($sformatf("u%0d out_valid a=%0h b=%0h", k, a, b), 64'(obs_vld[k]), 64'(o.vld));
                check($sformatf("u%0d p_raw a=%0h b=%0h", k, a, b), 64'(obs_raw[k]), 64'(o.raw[k]));
                check($sformatf("u%0d p_qm_n a=%0h b=%0h", k, a, b), 64'(obs_q[k]), 64'(o.q[k]));
                check($sformatf("u%0d overflow a=%0h b=%0h", k, a, b), 64'(obs_ovf[k]), 64'(o.ovf[k]));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s u%0d out_valid", tag, k), 64'(obs_vld[k]), 64'd0);
            check($sformatf("%s u%0d p_raw", tag, k), 64'(obs_raw[k]), 64'd0);
            check($sformatf("%s u%0d p_qm_n", tag, k), 64'(obs_q[k]), 64'd0);
            check($sformatf("%s u%0d overflow", tag, k), 64'(obs_ovf[k]), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid_s = 1'b0;
        a_s        = 8'h00;
        b_s        = 8'h00;
        rst_n      = 1'b1;
        clear_model();
        #1;
        rst_n = 1'b0;
        // A valid strobe during reset must not load anything.
        in_valid_s = 1'b1;
        a_s        = 8'hFF;
        b_s        = 8'hFF;
        @(posedge clk);
        #1;
        check_zero("reset");
        in_valid_s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Q5.3: 7.5 * 2.25 = 16.875
        step(1'b1, 8'h3C, 8'h12);
        check("tp1 p_raw", 64'(obs_raw[0]), 64'h0438);
        check("tp1 p_qm_n", 64'(obs_q[0]), 64'h87);
        check("tp1 overflow", 64'(obs_ovf[0]), 64'd0);
        check("tp1 out_valid", 64'(obs_vld[0]), 64'd1);

        // Q5.3 overflow: saturating clamps, wrapping keeps low bits of 428.
        step(1'b1, 8'h39, 8'h3C);
        check("tp2 p_raw", 64'(obs_raw[0]), 64'h0D5C);
        check("tp2 overflow sat", 64'(obs_ovf[0]), 64'd1);
        check("tp2 p_qm_n sat", 64'(obs_q[0]), 64'hFF);
        check("tp2 overflow wrap", 64'(obs_ovf[1]), 64'd1);
        check("tp2 p_qm_n wrap", 64'(obs_q[1]), 64'hAC);

        // Q3.5 instance.
        step(1'b1, 8'h12, 8'h05);
        check("tp3 p_raw q3.5", 64'(obs_raw[2]), 64'h005A);
        check("tp3 p_qm_n q3.5", 64'(obs_q[2]), 64'h03);
        check("tp3 overflow q3.5", 64'(obs_ovf[2]), 64'd0);

        // Rounding boundary: raw=4 rounds up to 1 LSB, raw=3 rounds down to 0.
        step(1'b1, 8'h01, 8'h04);
        check("tp4 half rounds up", 64'(obs_q[0]), 64'h01);
        step(1'b1, 8'h01, 8'h03);
        check("tp4 below half", 64'(obs_q[0]), 64'h00);

        // Idle cycle with changing operands: outputs must hold.
        step(1'b0, 8'hAA, 8'h55);

        // All-ones operands overflow in every format.
        step(1'b1, 8'hFF, 8'hFF);
        check("allones p_raw", 64'(obs_raw[0]), 64'hFE01);
        check("allones ovf q3.5", 64'(obs_ovf[2]), 64'd1);

        // Zero operand.
        step(1'b1, 8'h00, 8'h77);
        check("zero p_raw", 64'(obs_raw[1]), 64'd0);

        // Back-to-back sweep a=i, b=255-i.
        for (int i = 0; i <= 247; i += 13) begin
            step(1'b1, 8'(i), 8'(255 - i));
        end

        // Mixed valid/idle stream with random operands.
        for (int i = 0; i < 24; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // Mid-stream asynchronous reset between two valid inputs.
        step(1'b1, 8'h9B, 8'h27);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("async reset");
        in_valid_s = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h3C, 8'h12);
        check("post-reset p_qm_n", 64'(obs_q[0]), 64'h87);
        step(1'b1, 8'h5D, 8'hC4);
        step(1'b0, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
